// File: rtl/bus_rr_arbiter4_pkg.sv
// Shared lane geometry and FSM state type for the round-robin lane arbiter.
package bus_rr_arbiter4_pkg;

    localparam int unsigned LANE_W = 4;
    localparam int unsigned LANES  = 4;

    typedef enum logic [0:0] {
        StIdle,
        StGrant
    } arb_state_e;

endpackage

// File: rtl/bus_rr_arbiter4_rr_pick4.sv
// Round-robin winner selection: scan upward from last+1 with wrap.
module bus_rr_arbiter4_rr_pick4
    import bus_rr_arbiter4_pkg::*;
(
    input  logic [LANES-1:0] req,
    input  logic [1:0]       last,
    output logic [LANES-1:0] win_oh,
    output logic [1:0]       win_idx
);

    logic       found;
    logic [1:0] cand;

    // First requesting lane after the previous winner; 2-bit add wraps naturally.
    always_comb begin
        win_oh  = '0;
        win_idx = 2'd0;
        found   = 1'b0;
        cand    = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = last + 2'(k);
            if (!found && req[cand]) begin
                found   = 1'b1;
                win_idx = cand;
                win_oh  = 4'b0001 << cand;
            end
        end
    end

endmodule

// File: rtl/busmux4x4.sv
// Four-lane, 4-bit one-hot lane mux. A zero select yields a zero nibble.
module busmux4x4
    import bus_rr_arbiter4_pkg::*;
(
    input  logic [LANES-1:0]        sel,
    input  logic [LANES*LANE_W-1:0] lane_data,
    output logic [LANE_W-1:0]       mux_out
);

    // AND-OR reduction over the one-hot select.
    always_comb begin
        mux_out = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            if (sel[i]) begin
                mux_out = mux_out | lane_data[i*LANE_W +: LANE_W];
            end
        end
    end

endmodule

// File: rtl/bus_rr_arbiter4.sv
// Round-robin arbiter with bounded bursts feeding a registered valid/ready output.
module bus_rr_arbiter4
    import bus_rr_arbiter4_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LANES-1:0]        req,
    input  logic [LANES*LANE_W-1:0] lane_data,
    input  logic                    out_ready,
    output logic [LANES-1:0]        sel,
    output logic [LANES-1:0]        grant,
    output logic [LANE_W-1:0]       data_out,
    output logic [1:0]              data_src,
    output logic                    data_valid,
    output logic                    busy
);

    arb_state_e          state_q, state_d;
    logic [LANES-1:0]    sel_q, sel_d;
    logic [1:0]          win_idx_q, win_idx_d;
    logic [1:0]          last_q, last_d;
    logic [3:0]          beat_cnt_q, beat_cnt_d;
    logic [LANE_W-1:0]   data_out_q, data_out_d;
    logic [1:0]          data_src_q, data_src_d;
    logic                data_valid_q, data_valid_d;

    logic [LANES-1:0]    pick_oh;
    logic [1:0]          pick_idx;
    logic [LANE_W-1:0]   mux_out;
    logic                capture;
    logic                burst_done;

    bus_rr_arbiter4_rr_pick4 u_pick (
        .req     (req),
        .last    (last_q),
        .win_oh  (pick_oh),
        .win_idx (pick_idx)
    );

    busmux4x4 u_mux (
        .sel       (sel_q),
        .lane_data (lane_data),
        .mux_out   (mux_out)
    );

    // A beat is taken only while the winner still requests and the output slot is free.
    assign capture    = (state_q == StGrant) && req[win_idx_q] && (!data_valid_q || out_ready);
    assign burst_done = capture && (beat_cnt_q == 4'(MAX_BURST - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: arbitrate in idle, leave grant on request drop or full burst.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (|req) begin
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (!req[win_idx_q] || burst_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath next values: grant bookkeeping, beat counter and output slot.
    always_comb begin
        sel_d        = sel_q;
        win_idx_d    = win_idx_q;
        last_d       = last_q;
        beat_cnt_d   = beat_cnt_q;
        data_out_d   = data_out_q;
        data_src_d   = data_src_q;
        data_valid_d = data_valid_q;

        if ((state_q == StIdle) && (|req)) begin
            sel_d      = pick_oh;
            win_idx_d  = pick_idx;
            last_d     = pick_idx;
            beat_cnt_d = 4'd0;
        end else if ((state_q == StGrant) && (state_d == StIdle)) begin
            sel_d = '0;
        end

        if (capture) begin
            beat_cnt_d   = beat_cnt_q + 4'd1;
            data_out_d   = mux_out;
            data_src_d   = win_idx_q;
            data_valid_d = 1'b1;
        end else if (out_ready) begin
            data_valid_d = 1'b0;
        end
    end

    // Datapath registers; reset also drops any beat still waiting downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q        <= '0;
            win_idx_q    <= 2'd0;
            last_q       <= 2'd3;
            beat_cnt_q   <= 4'd0;
            data_out_q   <= '0;
            data_src_q   <= 2'd0;
            data_valid_q <= 1'b0;
        end else begin
            sel_q        <= sel_d;
            win_idx_q    <= win_idx_d;
            last_q       <= last_d;
            beat_cnt_q   <= beat_cnt_d;
            data_out_q   <= data_out_d;
            data_src_q   <= data_src_d;
            data_valid_q <= data_valid_d;
        end
    end

    // Outputs are straight from registers.
    always_comb begin
        sel        = sel_q;
        grant      = sel_q;
        busy       = (state_q == StGrant);
        data_out   = data_out_q;
        data_src   = data_src_q;
        data_valid = data_valid_q;
    end

endmodule
